// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: sequencer states, base opcodes and ALU operation codes.
package riscv_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  function automatic logic opcode_supported(input logic [6:0] opc);
    return opc inside {OP, OP_IMM, LOAD, STORE, BRANCH};
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU with zero flag.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // Operation select
  always_comb begin
    result = '0;
    unique case (ctrl)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = a + b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
      ALU_SLTU: result = XLEN'(a < b);
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/imm_gen.sv
// Immediate generator for I/S/B formats. B-type yields imm[12:1] sign-extended;
// the caller shifts it left by one when forming the branch target.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  logic [11:0] imm12;
  logic        unused_ir_bits;

  assign unused_ir_bits = ^ir[19:12];

  // Select the 12-bit immediate field by format
  always_comb begin
    imm12 = '0;
    unique case (ir[6:0])
      OP_IMM, LOAD: imm12 = ir[31:20];
      STORE:        imm12 = {ir[31:25], ir[11:7]};
      BRANCH:       imm12 = {ir[31], ir[7], ir[30:25], ir[11:8]};
      default:      imm12 = '0;
    endcase
  end

  assign imm = {{(XLEN-12){imm12[11]}}, imm12};

endmodule

// File: rtl/regfile.sv
// 32-entry register file, two async read ports, one write port; x0 reads as zero.
module regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [4:0]      rd_addr,
  input  logic            we,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data
);

  logic [XLEN-1:0] regs_q [32];

  // Register write; x0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      regs_q[rd_addr] <= wd;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle RV32I datapath: FETCH/DECODE/EXEC/MEM/WB sequencer with ready/valid
// stalls on instruction and data memory. Control bits come from an external
// decoder that watches ir_q.
module multicycle_datapath
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            instr_req,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic [31:0]     ir_q,
  input  logic            ALUSrc,
  input  logic [3:0]      ALUCtrl,
  input  logic            RegWrite,
  input  logic            MemToReg,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            Branch,
  output logic [XLEN-1:0] PC,
  output logic            dReq,
  output logic            dWe,
  output logic [XLEN-1:0] dAddress,
  output logic [XLEN-1:0] dWriteData,
  input  logic            dReady,
  input  logic [XLEN-1:0] dReadData,
  output logic            zero,
  output logic [XLEN-1:0] WriteBackData,
  output logic            retire,
  output logic            illegal
);

  localparam logic [XLEN-1:0] PC_RESET = XLEN'(INITIAL_PC);
  localparam logic [XLEN-1:0] FOUR     = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic            zero_q, zero_d;

  logic [XLEN-1:0] rs1_data, rs2_data, imm_dec, alu_b, alu_result;
  logic            alu_zero, rf_we;
  logic            instr_req_c, dreq_c, retire_c, illegal_c;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir  (ir_q),
    .imm (imm_dec)
  );

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst_n    (rst),
    .rs1_addr (ir_q[19:15]),
    .rs2_addr (ir_q[24:20]),
    .rd_addr  (ir_q[11:7]),
    .we       (rf_we),
    .wd       (WriteBackData),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  assign alu_b = ALUSrc ? imm_q : b_q;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .ctrl   (ALUCtrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Sequencer next-state, register updates and per-state strobes.
  // retire/illegal/dReq are decoded from the current state (and dReady in MEM)
  // so the completion pulse lands in the same cycle as the final state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    alu_out_d   = alu_out_q;
    mdr_d       = mdr_q;
    zero_d      = zero_q;
    instr_req_c = 1'b0;
    dreq_c      = 1'b0;
    retire_c    = 1'b0;
    illegal_c   = 1'b0;
    rf_we       = 1'b0;
    unique case (state_q)
      FETCH: begin
        instr_req_c = 1'b1;
        if (instr_valid) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d   = rs1_data;
        b_d   = rs2_data;
        imm_d = imm_dec;
        if (opcode_supported(ir_q[6:0])) begin
          state_d = EXEC;
        end else begin
          illegal_c = 1'b1;
          retire_c  = 1'b1;
          pc_d      = pc_q + FOUR;
          state_d   = FETCH;
        end
      end
      EXEC: begin
        alu_out_d = alu_result;
        zero_d    = alu_zero;
        if (MemRead || MemWrite) begin
          state_d = MEM;
        end else if (RegWrite) begin
          state_d = WB;
        end else begin
          retire_c = 1'b1;
          pc_d     = (Branch && alu_zero) ? pc_q + (imm_q << 1) : pc_q + FOUR;
          state_d  = FETCH;
        end
      end
      MEM: begin
        dreq_c = 1'b1;
        if (dReady) begin
          if (MemWrite) begin
            retire_c = 1'b1;
            pc_d     = pc_q + FOUR;
            state_d  = FETCH;
          end else begin
            mdr_d   = dReadData;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we    = RegWrite && (ir_q[11:7] != 5'd0);
        retire_c = 1'b1;
        pc_d     = pc_q + FOUR;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      zero_q    <= zero_d;
    end
  end

  // Strobes are forced low while reset is asserted
  assign instr_req     = rst & instr_req_c;
  assign dReq          = rst & dreq_c;
  assign dWe           = rst & dreq_c & MemWrite;
  assign retire        = rst & retire_c;
  assign illegal       = rst & illegal_c;
  assign PC            = pc_q;
  assign dAddress      = alu_out_q;
  assign dWriteData    = b_q;
  assign zero          = zero_q;
  assign WriteBackData = MemToReg ? mdr_q : alu_out_q;

endmodule
